// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, its binary index,
// and a hold limit that preempts a requester keeping the resource too long.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt,
    output logic       dbg_state
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_nxt;
    logic [7:0]        gnt_nxt;
    logic [2:0]        ptr, ptr_nxt;
    logic [2:0]        next_ptr;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              preempt_nxt;

    // First requester found scanning p, p+1, ..., p+7 (mod 8).
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        pick = p;
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (gnt[i]) gnt_idx = 3'(i);
        end
    end

    assign gnt_valid = |gnt;
    assign dbg_state = (state == GRANT);
    assign next_ptr  = gnt_idx + 3'd1;

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        preempt_nxt = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (en && |req) begin
                    gnt_nxt   = 8'b1 << pick(req, ptr);
                    hold_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (req[gnt_idx] && hold_cnt < HOLD_LAST) begin
                    hold_nxt = hold_cnt + 1'b1;
                end else begin
                    // The holder rotates to lowest priority before re-arbitration.
                    preempt_nxt = req[gnt_idx];
                    ptr_nxt     = next_ptr;
                    hold_nxt    = '0;
                    if (en && |req) begin
                        gnt_nxt = 8'b1 << pick(req, next_ptr);
                    end else begin
                        gnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            preempt  <= preempt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed vector table, reset corner sequences, and random
// traffic checked against a holder/pointer reference model.
module tb_rr_arbiter_8;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;
    logic       dbg_state;

    int total = 0;
    int bad   = 0;

    // Reference model: who holds, for how many cycles, and where the scan starts.
    int   m_holder;
    int   m_held;
    int   m_ptr;
    logic m_pre;

    typedef struct {
        logic [7:0] req;
        logic       en;
        int         idx;
        logic       valid;
        logic       pre;
    } vec_t;

    vec_t tbl[$];

    rr_arbiter_8 #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_holder = -1;
        m_held   = 0;
        m_ptr    = 0;
        m_pre    = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic e);
        int found;
        m_pre = 1'b0;
        if (m_holder >= 0) begin
            if (r[m_holder] && m_held < MAXH) begin
                m_held++;
            end else begin
                m_pre    = r[m_holder];
                m_ptr    = (m_holder + 1) % 8;
                m_holder = -1;
            end
        end
        if (m_holder < 0 && e && r != 8'h00) begin
            found = -1;
            for (int k = 0; k < 8; k++) begin
                if (found < 0 && r[(m_ptr + k) % 8]) found = (m_ptr + k) % 8;
            end
            m_holder = found;
            m_held   = 1;
        end
    endtask

    task automatic compare_model(input string tag);
        logic [7:0] eg;
        eg = (m_holder >= 0) ? 8'(1 << m_holder) : 8'h00;
        check({tag, ".gnt"},     32'(gnt),       32'(eg));
        check({tag, ".idx"},     32'(gnt_idx),   (m_holder >= 0) ? 32'(m_holder) : 32'd0);
        check({tag, ".valid"},   32'(gnt_valid), 32'(m_holder >= 0));
        check({tag, ".preempt"}, 32'(preempt),   32'(m_pre));
        check({tag, ".state"},   32'(dbg_state), 32'(m_holder >= 0));
    endtask

    // Called at a negedge: drive, let one rising edge happen, then sample at the negedge.
    task automatic cycle(input logic [7:0] r, input logic e, input string tag);
        req = r;
        en  = e;
        @(posedge clk);
        model_step(r, e);
        @(negedge clk);
        compare_model(tag);
    endtask

    task automatic do_reset();
        req   = 8'hFF;
        en    = 1'b1;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst.gnt",     32'(gnt),       32'd0);
            check("rst.idx",     32'(gnt_idx),   32'd0);
            check("rst.valid",   32'(gnt_valid), 32'd0);
            check("rst.preempt", 32'(preempt),   32'd0);
        end
        req   = 8'h00;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] cur;
        logic [7:0] eg;

        // Rotation: each holder drops its request for the cycle after its grant.
        tbl.push_back('{8'hFF, 1'b1, 0, 1'b1, 1'b0});
        tbl.push_back('{8'hFE, 1'b1, 1, 1'b1, 1'b0});
        tbl.push_back('{8'hFD, 1'b1, 2, 1'b1, 1'b0});
        tbl.push_back('{8'hFB, 1'b1, 3, 1'b1, 1'b0});
        tbl.push_back('{8'hF7, 1'b1, 4, 1'b1, 1'b0});
        tbl.push_back('{8'hEF, 1'b1, 5, 1'b1, 1'b0});
        tbl.push_back('{8'hDF, 1'b1, 6, 1'b1, 1'b0});
        tbl.push_back('{8'hBF, 1'b1, 7, 1'b1, 1'b0});
        tbl.push_back('{8'h7F, 1'b1, 0, 1'b1, 1'b0});
        tbl.push_back('{8'h00, 1'b1, 0, 1'b0, 1'b0});
        // Single requester, then release.
        tbl.push_back('{8'h04, 1'b1, 2, 1'b1, 1'b0});
        tbl.push_back('{8'h00, 1'b1, 0, 1'b0, 1'b0});
        // Enable gating, including en low mid-grant with another requester waiting.
        tbl.push_back('{8'h02, 1'b0, 0, 1'b0, 1'b0});
        tbl.push_back('{8'h02, 1'b0, 0, 1'b0, 1'b0});
        tbl.push_back('{8'h02, 1'b1, 1, 1'b1, 1'b0});
        tbl.push_back('{8'h02, 1'b0, 1, 1'b1, 1'b0});
        tbl.push_back('{8'h0A, 1'b0, 1, 1'b1, 1'b0});
        tbl.push_back('{8'h08, 1'b0, 0, 1'b0, 1'b0});
        // Hold limit: 4 and 5 alternate every MAXH cycles with no gap.
        tbl.push_back('{8'h30, 1'b1, 4, 1'b1, 1'b0});
        tbl.push_back('{8'h30, 1'b1, 4, 1'b1, 1'b0});
        tbl.push_back('{8'h30, 1'b1, 4, 1'b1, 1'b0});
        tbl.push_back('{8'h30, 1'b1, 4, 1'b1, 1'b0});
        tbl.push_back('{8'h30, 1'b1, 5, 1'b1, 1'b1});
        tbl.push_back('{8'h30, 1'b1, 5, 1'b1, 1'b0});
        tbl.push_back('{8'h30, 1'b1, 5, 1'b1, 1'b0});
        tbl.push_back('{8'h30, 1'b1, 5, 1'b1, 1'b0});
        tbl.push_back('{8'h30, 1'b1, 4, 1'b1, 1'b1});
        tbl.push_back('{8'h00, 1'b1, 0, 1'b0, 1'b0});
        // Sole requester is preempted and regranted back-to-back.
        tbl.push_back('{8'h01, 1'b1, 0, 1'b1, 1'b0});
        tbl.push_back('{8'h01, 1'b1, 0, 1'b1, 1'b0});
        tbl.push_back('{8'h01, 1'b1, 0, 1'b1, 1'b0});
        tbl.push_back('{8'h01, 1'b1, 0, 1'b1, 1'b0});
        tbl.push_back('{8'h01, 1'b1, 0, 1'b1, 1'b1});
        tbl.push_back('{8'h00, 1'b1, 0, 1'b0, 1'b0});

        req   = 8'h00;
        en    = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].req, tbl[i].en, $sformatf("vec%0d", i));
            eg = tbl[i].valid ? 8'(1 << tbl[i].idx) : 8'h00;
            check($sformatf("tbl%0d.gnt", i),     32'(gnt),       32'(eg));
            check($sformatf("tbl%0d.idx", i),     32'(gnt_idx),   32'(tbl[i].idx));
            check($sformatf("tbl%0d.valid", i),   32'(gnt_valid), 32'(tbl[i].valid));
            check($sformatf("tbl%0d.preempt", i), 32'(preempt),   32'(tbl[i].pre));
        end

        // Reset in the middle of a grant clears outputs without any clock edge.
        do_reset();
        @(negedge clk);
        cycle(8'h10, 1'b1, "mid.grant");
        check("mid.gnt_before", 32'(gnt), 32'h10);
        cycle(8'h10, 1'b1, "mid.hold");
        rst_n = 1'b0;
        #1;
        check("mid.gnt_async",   32'(gnt),       32'd0);
        check("mid.idx_async",   32'(gnt_idx),   32'd0);
        check("mid.valid_async", 32'(gnt_valid), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(8'hFF, 1'b1, "mid.after");
        check("mid.ptr_reset", 32'(gnt_idx), 32'd0);

        // Random traffic; requests persist for a while so the hold limit is exercised.
        cur = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       cur = 8'($urandom_range(0, 255));
                    1:       cur = 8'(1 << $urandom_range(0, 7));
                    default: cur = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
                endcase
            end
            cycle(cur, ($urandom_range(0, 9) != 0), $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
